// File: rtl/byteblast_core.sv
// byteblast_core: single-clock accumulator CPU with fetch/decode/execute/writeback sequencing.
// Program and data share one external synchronous RAM with one cycle of read latency.
`timescale 1ns/1ps
module byteblast_core #(
   parameter int DATA_BITS    = 8,
   parameter int ADDRESS_BITS = 5
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   output logic [ADDRESS_BITS-1:0] mem_addr,
   output logic                    mem_we,
   output logic [DATA_BITS-1:0]    mem_wdata,
   input  logic [DATA_BITS-1:0]    mem_rdata,
   output logic [DATA_BITS-1:0]    accu,
   output logic [ADDRESS_BITS-1:0] pc,
   output logic                    zero,
   output logic                    carry,
   output logic                    halted,
   output logic [2:0]              fde_state
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      WB     = 3'd3,
      HALT   = 3'd4
   } state_t;

   typedef enum logic [2:0] {
      OP_NOP = 3'b000,
      OP_LD  = 3'b001,
      OP_ADD = 3'b010,
      OP_SUB = 3'b011,
      OP_STR = 3'b100,
      OP_JMP = 3'b101,
      OP_JZ  = 3'b110,
      OP_HLT = 3'b111
   } opcode_t;

   state_t                  state;
   state_t                  next_state;
   opcode_t                 ir_opcode;
   logic [ADDRESS_BITS-1:0] ir_operand;
   logic [DATA_BITS:0]      sum;
   logic [DATA_BITS:0]      diff;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= FETCH;
      end else if (enable) begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         FETCH:  next_state = DECODE;
         DECODE: next_state = EXEC;
         EXEC: begin
            case (ir_opcode)
               OP_LD, OP_ADD, OP_SUB: next_state = WB;
               OP_HLT:                next_state = HALT;
               default:               next_state = FETCH;
            endcase
         end
         WB:     next_state = FETCH;
         HALT:   next_state = HALT;
         default: next_state = FETCH;
      endcase
   end

   // The top bit of each extended result is the carry out of ADD or the borrow of SUB.
   assign sum  = {1'b0, accu} + {1'b0, mem_rdata};
   assign diff = {1'b0, accu} - {1'b0, mem_rdata};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc         <= '0;
         ir_opcode  <= OP_NOP;
         ir_operand <= '0;
         accu       <= '0;
         zero       <= 1'b0;
         carry      <= 1'b0;
      end else if (enable) begin
         case (state)
            DECODE: begin
               ir_opcode  <= opcode_t'(mem_rdata[DATA_BITS-1 -: 3]);
               ir_operand <= mem_rdata[ADDRESS_BITS-1:0];
               pc         <= pc + ADDRESS_BITS'(1);
            end
            EXEC: begin
               if (ir_opcode == OP_JMP || (ir_opcode == OP_JZ && zero)) begin
                  pc <= ir_operand;
               end
            end
            WB: begin
               case (ir_opcode)
                  OP_LD: begin
                     accu <= mem_rdata;
                     zero <= (mem_rdata == '0);
                  end
                  OP_ADD: begin
                     {carry, accu} <= sum;
                     zero          <= (sum[DATA_BITS-1:0] == '0);
                  end
                  OP_SUB: begin
                     {carry, accu} <= diff;
                     zero          <= (diff[DATA_BITS-1:0] == '0);
                  end
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

   // Address is derived from frozen state, so a stall naturally holds it.
   always_comb begin
      mem_addr = pc;
      case (state)
         EXEC, WB: mem_addr = ir_operand;
         default:  mem_addr = pc;
      endcase
   end

   assign mem_we    = enable && (state == EXEC) && (ir_opcode == OP_STR);
   assign mem_wdata = accu;
   assign halted    = (state == HALT);
   assign fde_state = state;

endmodule

// File: tb/tb_byteblast_core.sv
// Directed bench for byteblast_core: default 8/5 build plus a 12/9 build, each with its own RAM model.
`timescale 1ns/1ps
module tb_byteblast_core;

   logic        clk;
   logic        reset;
   logic        reset_w;
   logic        enable;

   logic [4:0]  mem_addr;
   logic        mem_we;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic [7:0]  accu;
   logic [4:0]  pc;
   logic        zero;
   logic        carry;
   logic        halted;
   logic [2:0]  fde_state;

   logic [8:0]  mem_addr_w;
   logic        mem_we_w;
   logic [11:0] mem_wdata_w;
   logic [11:0] mem_rdata_w;
   logic [11:0] accu_w;
   logic [8:0]  pc_w;
   logic        zero_w;
   logic        carry_w;
   logic        halted_w;
   logic [2:0]  fde_state_w;

   logic [7:0]  mem   [0:31];
   logic [11:0] mem_w [0:511];

   int vectors;
   int miscompares;
   int write_count;

   byteblast_core dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .accu      (accu),
      .pc        (pc),
      .zero      (zero),
      .carry     (carry),
      .halted    (halted),
      .fde_state (fde_state)
   );

   byteblast_core #(.DATA_BITS(12), .ADDRESS_BITS(9)) dut_wide (
      .clk       (clk),
      .reset     (reset_w),
      .enable    (enable),
      .mem_addr  (mem_addr_w),
      .mem_we    (mem_we_w),
      .mem_wdata (mem_wdata_w),
      .mem_rdata (mem_rdata_w),
      .accu      (accu_w),
      .pc        (pc_w),
      .zero      (zero_w),
      .carry     (carry_w),
      .halted    (halted_w),
      .fde_state (fde_state_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      mem_rdata <= mem[mem_addr];
      if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
         write_count   <= write_count + 1;
      end
   end

   always @(posedge clk) begin
      mem_rdata_w <= mem_w[mem_addr_w];
      if (mem_we_w) begin
         mem_w[mem_addr_w] <= mem_wdata_w;
      end
   end

   task automatic run_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Holds the default core in reset and clears its RAM to NOPs.
   task automatic apply_stimulus();
      reset  = 1'b0;
      enable = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 32; i++) mem[i] = 8'h00;
      write_count = 0;
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      write_count = 0;
      reset       = 1'b0;
      reset_w     = 1'b0;
      enable      = 1'b1;
      for (int i = 0; i < 512; i++) mem_w[i] = 12'h000;

      $display("[TB] program run");
      apply_stimulus();
      mem[0] = 8'h24; mem[1] = 8'h45; mem[2] = 8'h86; mem[3] = 8'hE0;
      mem[4] = 8'h02; mem[5] = 8'h05;
      #1;
      check_output("rst_state",  32'(fde_state), 32'd0);
      check_output("rst_pc",     32'(pc),        32'd0);
      check_output("rst_accu",   32'(accu),      32'd0);
      check_output("rst_zero",   32'(zero),      32'd0);
      check_output("rst_carry",  32'(carry),     32'd0);
      check_output("rst_halted", 32'(halted),    32'd0);
      check_output("rst_we",     32'(mem_we),    32'd0);
      check_output("rst_addr",   32'(mem_addr),  32'd0);
      check_output("rst_wdata",  32'(mem_wdata), 32'd0);
      release_reset();
      run_cycles(4);
      check_output("prog_c4_accu",  32'(accu),      32'd2);
      check_output("prog_c4_state", 32'(fde_state), 32'd0);
      run_cycles(4);
      check_output("prog_c8_accu",  32'(accu),      32'd7);
      check_output("prog_c8_carry", 32'(carry),     32'd0);
      run_cycles(2);
      check_output("prog_c10_we",    32'(mem_we),    32'd1);
      check_output("prog_c10_addr",  32'(mem_addr),  32'd6);
      check_output("prog_c10_wdata", 32'(mem_wdata), 32'd7);
      run_cycles(3);
      check_output("prog_c13_halted", 32'(halted),    32'd0);
      check_output("prog_c13_state",  32'(fde_state), 32'd2);
      run_cycles(1);
      check_output("prog_c14_halted", 32'(halted),    32'd1);
      check_output("prog_c14_state",  32'(fde_state), 32'd4);
      check_output("prog_c14_pc",     32'(pc),        32'd4);
      run_cycles(5);
      check_output("prog_late_halted", 32'(halted),      32'd1);
      check_output("prog_late_pc",     32'(pc),          32'd4);
      check_output("prog_late_we",     32'(mem_we),      32'd0);
      check_output("prog_m6",          32'(mem[6]),      32'd7);
      check_output("prog_writes",      32'(write_count), 32'd1);

      $display("[TB] ADD overflow");
      apply_stimulus();
      mem[0] = 8'h28; mem[1] = 8'h49; mem[2] = 8'hE0;
      mem[8] = 8'hFF; mem[9] = 8'h01;
      release_reset();
      run_cycles(4);
      check_output("addov_ld_accu", 32'(accu), 32'hFF);
      check_output("addov_ld_zero", 32'(zero), 32'd0);
      run_cycles(4);
      check_output("addov_accu",  32'(accu),  32'h00);
      check_output("addov_carry", 32'(carry), 32'd1);
      check_output("addov_zero",  32'(zero),  32'd1);

      $display("[TB] SUB borrow");
      apply_stimulus();
      mem[0] = 8'h28; mem[1] = 8'h69; mem[2] = 8'hE0;
      mem[8] = 8'h03; mem[9] = 8'h05;
      release_reset();
      run_cycles(8);
      check_output("subb_accu",  32'(accu),  32'hFE);
      check_output("subb_carry", 32'(carry), 32'd1);
      check_output("subb_zero",  32'(zero),  32'd0);

      $display("[TB] SUB equal");
      apply_stimulus();
      mem[0] = 8'h28; mem[1] = 8'h69; mem[2] = 8'hE0;
      mem[8] = 8'h05; mem[9] = 8'h05;
      release_reset();
      run_cycles(8);
      check_output("sube_accu",  32'(accu),  32'h00);
      check_output("sube_carry", 32'(carry), 32'd0);
      check_output("sube_zero",  32'(zero),  32'd1);

      $display("[TB] JZ taken");
      apply_stimulus();
      mem[0] = 8'h28; mem[1] = 8'hCA; mem[8] = 8'h00;
      release_reset();
      run_cycles(4);
      check_output("jzt_zero", 32'(zero), 32'd1);
      run_cycles(3);
      check_output("jzt_state", 32'(fde_state), 32'd0);
      check_output("jzt_addr",  32'(mem_addr),  32'd10);

      $display("[TB] JZ not taken");
      apply_stimulus();
      mem[0] = 8'h29; mem[1] = 8'h00; mem[2] = 8'hD4; mem[9] = 8'h01;
      release_reset();
      run_cycles(10);
      check_output("jzn_state", 32'(fde_state), 32'd0);
      check_output("jzn_addr",  32'(mem_addr),  32'd3);

      $display("[TB] PC wrap");
      apply_stimulus();
      mem[0] = 8'hBF; mem[31] = 8'h00;
      release_reset();
      run_cycles(3);
      check_output("wrap_jmp_addr", 32'(mem_addr), 32'd31);
      run_cycles(3);
      check_output("wrap_state", 32'(fde_state), 32'd0);
      check_output("wrap_addr",  32'(mem_addr),  32'd0);
      check_output("wrap_pc",    32'(pc),        32'd0);

      $display("[TB] enable stall during STR");
      apply_stimulus();
      mem[0] = 8'h28; mem[1] = 8'h8C; mem[2] = 8'hE0; mem[8] = 8'h5A;
      release_reset();
      run_cycles(6);
      check_output("stall_pre_state", 32'(fde_state), 32'd2);
      check_output("stall_pre_we",    32'(mem_we),    32'd1);
      check_output("stall_pre_addr",  32'(mem_addr),  32'd12);
      enable = 1'b0;
      #1;
      check_output("stall_we_low", 32'(mem_we), 32'd0);
      for (int i = 0; i < 5; i++) begin
         run_cycles(1);
         check_output("stall_state", 32'(fde_state), 32'd2);
         check_output("stall_we",    32'(mem_we),    32'd0);
      end
      check_output("stall_addr",   32'(mem_addr),    32'd12);
      check_output("stall_pc",     32'(pc),          32'd2);
      check_output("stall_nowr",   32'(write_count), 32'd0);
      enable = 1'b1;
      #1;
      check_output("stall_resume_we", 32'(mem_we), 32'd1);
      run_cycles(1);
      check_output("stall_post_state", 32'(fde_state), 32'd0);
      check_output("stall_post_we",    32'(mem_we),    32'd0);
      run_cycles(3);
      check_output("stall_halted", 32'(halted),      32'd1);
      check_output("stall_writes", 32'(write_count), 32'd1);
      check_output("stall_m12",    32'(mem[12]),     32'h5A);

      $display("[TB] reset during STR");
      apply_stimulus();
      mem[0] = 8'h28; mem[1] = 8'h8C; mem[2] = 8'hE0; mem[8] = 8'h5A;
      release_reset();
      run_cycles(6);
      check_output("rststr_pre_we",   32'(mem_we), 32'd1);
      check_output("rststr_pre_accu", 32'(accu),   32'h5A);
      reset = 1'b0;
      #1;
      check_output("rststr_we",    32'(mem_we),    32'd0);
      check_output("rststr_pc",    32'(pc),        32'd0);
      check_output("rststr_accu",  32'(accu),      32'd0);
      check_output("rststr_state", 32'(fde_state), 32'd0);
      check_output("rststr_addr",  32'(mem_addr),  32'd0);
      run_cycles(2);
      check_output("rststr_nowr", 32'(write_count), 32'd0);
      check_output("rststr_m12",  32'(mem[12]),     32'h00);
      release_reset();
      run_cycles(4);
      check_output("rststr_restart_accu", 32'(accu), 32'h5A);
      check_output("rststr_restart_pc",   32'(pc),   32'd1);

      $display("[TB] wide parameters");
      mem_w[0]   = 12'h32C;
      mem_w[1]   = 12'h52D;
      mem_w[2]   = 12'hE00;
      mem_w[300] = 12'hABC;
      mem_w[301] = 12'h545;
      @(negedge clk);
      reset_w = 1'b1;
      run_cycles(4);
      check_output("wide_ld_accu", 32'(accu_w), 32'hABC);
      run_cycles(4);
      check_output("wide_accu",  32'(accu_w),  32'h001);
      check_output("wide_carry", 32'(carry_w), 32'd1);
      check_output("wide_zero",  32'(zero_w),  32'd0);
      run_cycles(3);
      check_output("wide_halted", 32'(halted_w), 32'd1);
      check_output("wide_pc",     32'(pc_w),     32'd3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
